// File: rtl/xadc_drp_arbiter_if.sv
// xadc_drp_arbiter_if: client request/response and XADC DRP signals; write fields present only with DRP_WRITE_EN
interface xadc_drp_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 drp_den;
  logic [6:0]           drp_daddr;
  logic                 drp_dwe;
  logic [15:0]          drp_di;
  logic [15:0]          drp_do;
  logic                 drp_drdy;
`ifdef DRP_WRITE_EN
  logic [NUM_REQ-1:0]    req_we;
  logic [16*NUM_REQ-1:0] req_wdata;
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, drp_do, drp_drdy,
    output req_ready, rsp_valid, rsp_data, rsp_err, drp_den, drp_daddr, drp_dwe, drp_di
  );
  modport master (
    output req_valid, req_addr, req_we, req_wdata, drp_do, drp_drdy,
    input  req_ready, rsp_valid, rsp_data, rsp_err, drp_den, drp_daddr, drp_dwe, drp_di
  );
`else
  modport slave (
    input  req_valid, req_addr, drp_do, drp_drdy,
    output req_ready, rsp_valid, rsp_data, rsp_err, drp_den, drp_daddr, drp_dwe, drp_di
  );
  modport master (
    output req_valid, req_addr, drp_do, drp_drdy,
    input  req_ready, rsp_valid, rsp_data, rsp_err, drp_den, drp_daddr, drp_dwe, drp_di
  );
`endif
endinterface

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: round-robin sharing of one XADC DRP among NUM_REQ clients with a drdy watchdog; DRP_WRITE_EN adds client writes
module xadc_drp_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  output logic busy,
  xadc_drp_arbiter_if.slave io
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, gnt, g_q, cand;
  logic gnt_any, timeout, wr;
  logic [6:0] addr_q;
  logic [9:0] cnt;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0] rsp_data_q, wdata;
`ifdef DRP_WRITE_EN
  logic we_q;
  logic [15:0] wdata_q;
  assign wr = we_q;
  assign wdata = wdata_q;
`else
  assign wr = 1'b0;
  assign wdata = 16'h0000;
`endif
  logic rsp_err_q;
  assign timeout = cnt == 10'(TIMEOUT_CYC - 1);
  assign busy = state != IDLE;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data = rsp_data_q;
  assign io.rsp_err = rsp_err_q;
  assign io.drp_daddr = addr_q;
  // first requester searching cyclically from the client after the last winner
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && io.req_valid[cand]) begin
        gnt = cand;
        gnt_any = 1'b1;
      end
    end
  end
  // next state and DRP/handshake strobes
  always_comb begin
    state_n = state == IDLE ? (gnt_any ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              (io.drp_drdy || timeout) ? IDLE : WAIT;
    io.req_ready = (state == IDLE && gnt_any && reset_n) ? NUM_REQ'(1) << gnt : '0;
    io.drp_den = state == ISSUE;
    io.drp_dwe = state == ISSUE && wr;
    io.drp_di = (state == ISSUE && wr) ? wdata : 16'h0000;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // grant latch, watchdog counter and registered response
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_ptr <= PW'(NUM_REQ - 1);
      g_q <= '0;
      addr_q <= '0;
      cnt <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef DRP_WRITE_EN
      we_q <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      cnt <= state == WAIT ? cnt + 10'd1 : '0;
      if (state == IDLE && gnt_any) begin
        rr_ptr <= gnt;
        g_q <= gnt;
        addr_q <= io.req_addr[7*gnt +: 7];
`ifdef DRP_WRITE_EN
        we_q <= io.req_we[gnt];
        wdata_q <= io.req_wdata[16*gnt +: 16];
`endif
      end
      if (state == WAIT && (io.drp_drdy || timeout)) begin
        rsp_valid_q <= NUM_REQ'(1) << g_q;
        rsp_data_q <= (io.drp_drdy && !wr) ? io.drp_do : 16'h0000;
        rsp_err_q <= !io.drp_drdy;
      end
    end
endmodule
